// File: rtl/rtmc_pkg.sv
// rtmc_pkg: shared types and constants for the motor-controller register bus.
//   reg_arb_state_t : arbiter sequencing states (IDLE, ISSUE, WAIT, ACK)
//   REG_ERR_RDAT    : read word returned to an initiator when the responder
//                     never acknowledges within the timeout window
package rtmc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } reg_arb_state_t;

  localparam logic [15:0] REG_ERR_RDAT = 16'hDEAD;

endpackage

// File: rtl/rtmc_reg_arb.sv
// rtmc_reg_arb: two-initiator round-robin arbiter in front of one register
// responder. Each granted access becomes a single-cycle r_wr/r_rd strobe;
// completion is returned as a one-cycle iN_ack pulse with iN_rdat.
// A bounded wait returns REG_ERR_RDAT and sets a sticky timeout_err.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   iN_addr/wdat/wr/rd    initiator N request (held until iN_ack)
//   iN_rdat, iN_ack       initiator N completion (rdat is 0 while ack is low)
//   r_addr/r_wdat         registered address/data toward the responder
//   r_wr/r_rd             one-cycle responder strobes
//   r_rdat, r_ack         responder read data and completion pulse
//   err_clr, timeout_err  clear input and sticky timeout flag
module rtmc_reg_arb
  import rtmc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i0_addr,
  input  logic [DATA_W-1:0] i0_wdat,
  input  logic              i0_wr,
  input  logic              i0_rd,
  output logic [DATA_W-1:0] i0_rdat,
  output logic              i0_ack,
  input  logic [ADDR_W-1:0] i1_addr,
  input  logic [DATA_W-1:0] i1_wdat,
  input  logic              i1_wr,
  input  logic              i1_rd,
  output logic [DATA_W-1:0] i1_rdat,
  output logic              i1_ack,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_wdat,
  output logic              r_wr,
  output logic              r_rd,
  input  logic [DATA_W-1:0] r_rdat,
  input  logic              r_ack,
  input  logic              err_clr,
  output logic              timeout_err
);

  // 9-bit compare so counter+1 never wraps against the limit
  localparam logic [8:0]        TO_LIMIT = 9'(TIMEOUT_CYC);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(REG_ERR_RDAT);

  reg_arb_state_t    state_reg;
  logic              last_gnt_reg;  // 1 = i1 was granted last
  logic              gnt_reg;       // 0 = i0 owns the bus, 1 = i1
  logic [7:0]        cnt_reg;
  logic [DATA_W-1:0] rdat_q;

  logic req0, req1, pick_i1, pick_wr;
  logic to_hit, complete, timed_out;
  logic [DATA_W-1:0] done_data;

  assign req0 = i0_wr | i0_rd;
  assign req1 = i1_wr | i1_rd;

  // Lone requester wins; on a tie the initiator that was not granted last wins.
  assign pick_i1 = req1 & (~req0 | ~last_gnt_reg);
  // wr dominates rd when both are raised together
  assign pick_wr = pick_i1 ? i1_wr : i0_wr;

  // Completion decision for the current ISSUE/WAIT cycle. An ack always
  // beats a timeout landing in the same cycle. ISSUE only times out when
  // the window is a single cycle long.
  always_comb begin
    to_hit    = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    done_data = r_rdat;
    if (state_reg == ISSUE) begin
      to_hit = (TO_LIMIT <= 9'd1);
    end else if (state_reg == WAIT) begin
      to_hit = ({1'b0, cnt_reg} + 9'd1) >= TO_LIMIT;
    end
    if (state_reg == ISSUE || state_reg == WAIT) begin
      if (r_ack) begin
        complete = 1'b1;
      end else if (to_hit) begin
        complete  = 1'b1;
        timed_out = 1'b1;
        done_data = ERR_WORD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      gnt_reg      <= 1'b0;
      cnt_reg      <= '0;
      rdat_q       <= '0;
      r_addr       <= '0;
      r_wdat       <= '0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      i0_ack       <= 1'b0;
      i1_ack       <= 1'b0;
      i0_rdat      <= '0;
      i1_rdat      <= '0;
      timeout_err  <= 1'b0;
    end else begin
      // Pulsed outputs default low; only the transitions below raise them.
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      i0_ack  <= 1'b0;
      i1_ack  <= 1'b0;
      i0_rdat <= '0;
      i1_rdat <= '0;

      // Clear first so a timeout in the same cycle still leaves the flag set.
      if (err_clr) timeout_err <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req0 | req1) begin
            gnt_reg      <= pick_i1;
            last_gnt_reg <= pick_i1;
            r_addr       <= pick_i1 ? i1_addr : i0_addr;
            r_wdat       <= pick_i1 ? i1_wdat : i0_wdat;
            // The strobe flops hold the latched op; they are high exactly
            // for the ISSUE cycle.
            r_wr         <= pick_wr;
            r_rd         <= ~pick_wr;
            state_reg    <= ISSUE;
          end
        end

        ISSUE, WAIT: begin
          cnt_reg <= (state_reg == ISSUE) ? 8'd1 : cnt_reg + 8'd1;
          if (complete) begin
            rdat_q <= done_data;
            // Ack and data are raised on entry to ACK so they are registered.
            if (gnt_reg) begin
              i1_ack  <= 1'b1;
              i1_rdat <= done_data;
            end else begin
              i0_ack  <= 1'b1;
              i0_rdat <= done_data;
            end
            if (timed_out) timeout_err <= 1'b1;
            state_reg <= ACK;
          end else begin
            state_reg <= WAIT;
          end
        end

        ACK: begin
          // r_ack here or later belongs to an abandoned/finished access.
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtmc_reg_arb.sv
module tb_rtmc_reg_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i0_addr, i1_addr;
  logic [15:0] i0_wdat, i1_wdat;
  logic        i0_wr, i0_rd, i1_wr, i1_rd;
  logic [15:0] i0_rdat, i1_rdat;
  logic        i0_ack, i1_ack;
  logic [7:0]  r_addr;
  logic [15:0] r_wdat;
  logic        r_wr, r_rd;
  logic [15:0] r_rdat;
  logic        r_ack;
  logic        err_clr;
  logic        timeout_err;

  always #5 clk = ~clk;

  rtmc_reg_arb #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .i0_addr(i0_addr), .i0_wdat(i0_wdat), .i0_wr(i0_wr), .i0_rd(i0_rd),
    .i0_rdat(i0_rdat), .i0_ack(i0_ack),
    .i1_addr(i1_addr), .i1_wdat(i1_wdat), .i1_wr(i1_wr), .i1_rd(i1_rd),
    .i1_rdat(i1_rdat), .i1_ack(i1_ack),
    .r_addr(r_addr), .r_wdat(r_wdat), .r_wr(r_wr), .r_rd(r_rd),
    .r_rdat(r_rdat), .r_ack(r_ack),
    .err_clr(err_clr), .timeout_err(timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ini;      // requesting initiator
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] wdat;
    int          dly;      // responder ack delay after strobe, -1 = never
    logic [15:0] resp;     // responder read data
    int          ack_cyc;  // expected ack cycle (request seen in cycle 0)
    logic [15:0] rdat;     // expected iN_rdat at ack
    logic        err;      // expected timeout_err afterwards
  } vec_t;

  vec_t vecs[5];
  vec_t t;

  int   n_wr, n_rd, st_cyc, ack_cyc, acks_seen, g, n0, n1, last_ini, ini;
  logic [7:0]  st_addr;
  logic [15:0] st_wdat, ack_rdat;
  logic        other_bad, leak, bad, my_ack, oth_ack;
  logic [15:0] my_rdat, oth_rdat;
  int          exp_order[4];

  task automatic set_req(input int who, input logic wr, input logic rd,
                         input logic [7:0] a, input logic [15:0] d);
    if (who == 0) begin
      i0_addr = a; i0_wdat = d; i0_wr = wr; i0_rd = rd;
    end else begin
      i1_addr = a; i1_wdat = d; i1_wr = wr; i1_rd = rd;
    end
  endtask

  initial begin
    vecs[0] = '{ini:0, wr:1, rd:0, addr:8'h12, wdat:16'hBEEF, dly:2,  resp:16'h5555, ack_cyc:4,  rdat:16'h5555, err:0};
    vecs[1] = '{ini:1, wr:0, rd:1, addr:8'h05, wdat:16'h0000, dly:0,  resp:16'h1234, ack_cyc:2,  rdat:16'h1234, err:0};
    vecs[2] = '{ini:0, wr:1, rd:1, addr:8'h33, wdat:16'h0F0F, dly:1,  resp:16'hAAAA, ack_cyc:3,  rdat:16'hAAAA, err:0};
    vecs[3] = '{ini:1, wr:0, rd:1, addr:8'h7F, wdat:16'h0000, dly:13, resp:16'h4321, ack_cyc:15, rdat:16'h4321, err:0};
    vecs[4] = '{ini:0, wr:0, rd:1, addr:8'h5A, wdat:16'h0000, dly:-1, resp:16'h0000, ack_cyc:16, rdat:16'hDEAD, err:1};

    rst = 1'b1; err_clr = 1'b0; r_ack = 1'b0; r_rdat = '0;
    set_req(0, 0, 0, 8'h00, 16'h0000);
    set_req(1, 0, 0, 8'h00, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_r_addr_wdat", {r_addr, r_wdat}, 64'h0);
    check("reset_strobes_acks_err", {r_wr, r_rd, i0_ack, i1_ack, timeout_err}, 64'h0);
    check("reset_rdat", {i0_rdat, i1_rdat}, 64'h0);

    // ---------------- table-driven single transactions ----------------
    for (int v = 0; v < 5; v++) begin
      t = vecs[v];
      set_req(t.ini, t.wr, t.rd, t.addr, t.wdat);
      n_wr = 0; n_rd = 0; st_cyc = -1; ack_cyc = -1; acks_seen = 0;
      st_addr = '0; st_wdat = '0; ack_rdat = '0; other_bad = 0; leak = 0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        r_ack = 1'b0; r_rdat = '0;
        if (r_wr) n_wr++;
        if (r_rd) n_rd++;
        if ((r_wr || r_rd) && st_cyc < 0) begin
          st_cyc = c; st_addr = r_addr; st_wdat = r_wdat;
        end
        my_ack   = (t.ini == 1) ? i1_ack  : i0_ack;
        my_rdat  = (t.ini == 1) ? i1_rdat : i0_rdat;
        oth_ack  = (t.ini == 1) ? i0_ack  : i1_ack;
        oth_rdat = (t.ini == 1) ? i0_rdat : i1_rdat;
        if (oth_ack || oth_rdat != 16'h0) other_bad = 1;
        if (!my_ack && my_rdat != 16'h0) leak = 1;
        if (my_ack) begin
          acks_seen++;
          if (ack_cyc < 0) begin
            ack_cyc = c; ack_rdat = my_rdat;
          end
          set_req(t.ini, 0, 0, t.addr, t.wdat);
        end
        if (st_cyc >= 1 && t.dly >= 0 && c == st_cyc + t.dly) begin
          r_ack = 1'b1; r_rdat = t.resp;
        end
      end
      $display("TXN vec%0d ini=%0d addr=%0h strobe_cyc=%0d ack_cyc=%0d rdat=%0h err=%0b",
               v, t.ini, t.addr, st_cyc, ack_cyc, ack_rdat, timeout_err);
      check($sformatf("vec%0d_r_wr_count", v), n_wr, (t.wr) ? 1 : 0);
      check($sformatf("vec%0d_r_rd_count", v), n_rd, (t.rd && !t.wr) ? 1 : 0);
      check($sformatf("vec%0d_strobe_cycle", v), st_cyc, 1);
      check($sformatf("vec%0d_r_addr", v), st_addr, t.addr);
      check($sformatf("vec%0d_r_wdat", v), st_wdat, t.wdat);
      check($sformatf("vec%0d_ack_cycle", v), ack_cyc, t.ack_cyc);
      check($sformatf("vec%0d_ack_count", v), acks_seen, 1);
      check($sformatf("vec%0d_ack_rdat", v), ack_rdat, t.rdat);
      check($sformatf("vec%0d_other_quiet", v), other_bad, 0);
      check($sformatf("vec%0d_rdat_zero_no_ack", v), leak, 0);
      check($sformatf("vec%0d_timeout_err", v), timeout_err, t.err);
    end

    // ---------------- late ack after timeout is ignored ----------------
    @(negedge clk);
    r_ack = 1'b1; r_rdat = 16'h7777;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      r_ack = 1'b0; r_rdat = '0;
      if (i0_ack || i1_ack || r_wr || r_rd) bad = 1;
    end
    $display("TXN late_ack ignored=%0b timeout_err=%0b", !bad, timeout_err);
    check("late_ack_ignored", bad, 0);
    check("timeout_err_sticky", timeout_err, 1);

    // ---------------- err_clr ----------------
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    $display("TXN err_clr timeout_err=%0b", timeout_err);
    check("err_clr_clears", timeout_err, 0);

    // ---------------- reset mid-transaction ----------------
    set_req(0, 0, 1, 8'h40, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) set_req(1, 1, 0, 8'h41, 16'h1111);
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_r_addr_wdat", {r_addr, r_wdat}, 64'h0);
    check("async_rst_strobes_acks_err", {r_wr, r_rd, i0_ack, i1_ack, timeout_err}, 64'h0);
    check("async_rst_rdat", {i0_rdat, i1_rdat}, 64'h0);
    set_req(0, 0, 0, 8'h00, 16'h0000);  // abandoned access is not re-requested
    @(negedge clk);
    rst = 1'b0;
    st_addr = '0; st_cyc = -1; ack_cyc = -1; bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      r_ack = 1'b0; r_rdat = '0;
      if (i0_ack) bad = 1;
      if (i1_ack && ack_cyc < 0) begin
        ack_cyc = c; set_req(1, 0, 0, 8'h41, 16'h1111);
      end
      if ((r_wr || r_rd) && st_cyc < 0) begin
        st_cyc = c; st_addr = r_addr;
        r_ack = 1'b1; r_rdat = 16'h0BAD;
      end
    end
    $display("TXN post_reset first_addr=%0h i1_ack_cyc=%0d i0_acked=%0b", st_addr, ack_cyc, bad);
    check("post_reset_grant_i1", st_addr, 8'h41);
    check("post_reset_i1_ack_cycle", ack_cyc, 2);
    check("post_reset_no_i0_ack", bad, 0);

    // ---------------- simultaneous requests: round robin ----------------
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    n0 = 0; n1 = 0; g = 0; acks_seen = 0; last_ini = -1;
    set_req(0, 0, 1, 8'h10, 16'h0000);
    set_req(1, 1, 0, 8'h20, 16'h2000);
    for (int c = 1; c <= 40 && acks_seen < 4; c++) begin
      @(negedge clk);
      r_ack = 1'b0; r_rdat = '0;
      if (i0_ack) begin
        acks_seen++;
        $display("TXN rr ack i0 rdat=%0h", i0_rdat);
        check("rr_i0_ack_owner", last_ini, 0);
        check("rr_i0_rdat", i0_rdat, {8'hC0, 8'h10 + 8'(n0)});
        n0++;
        if (n0 < 2) set_req(0, 0, 1, 8'h10 + 8'(n0), 16'h0000);
        else        set_req(0, 0, 0, 8'h00, 16'h0000);
      end
      if (i1_ack) begin
        acks_seen++;
        $display("TXN rr ack i1 rdat=%0h", i1_rdat);
        check("rr_i1_ack_owner", last_ini, 1);
        check("rr_i1_rdat", i1_rdat, {8'hC0, 8'h20 + 8'(n1)});
        n1++;
        if (n1 < 2) set_req(1, 1, 0, 8'h20 + 8'(n1), 16'h2000 + 16'(n1));
        else        set_req(1, 0, 0, 8'h00, 16'h0000);
      end
      if (r_wr || r_rd) begin
        ini = (r_addr[7:4] == 4'h2) ? 1 : 0;
        if (g < 4) check($sformatf("rr_grant%0d", g), ini, exp_order[g]);
        check($sformatf("rr_op%0d", g), {r_wr, r_rd}, (ini == 1) ? 2'b10 : 2'b01);
        g++;
        last_ini = ini;
        r_ack = 1'b1; r_rdat = {8'hC0, r_addr};
      end
    end
    check("rr_total_grants", g, 4);
    check("rr_total_acks", acks_seen, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtmc_reg_arb.md
# rtmc_reg_arb

Two-initiator register-bus arbiter for the motor-controller register file. It shares one register responder between initiator 0 (SPI command bridge) and initiator 1 (on-chip motion sequencer) and grants them round-robin. Each transaction is serialized into a single-cycle strobe toward the responder. A bounded-wait timeout returns an error word if the responder never acknowledges.

## Interface
Parameters:
- ADDR_W, 8, register address width
- DATA_W, 16, register data width
- TIMEOUT_CYC, 15, cycles to wait for responder ack before forcing completion (1..255)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- i0_addr / i1_addr  input  ADDR_W  initiator address, held until that initiator's ack
- i0_wdat / i1_wdat  input  DATA_W  write data, held until ack
- i0_wr / i1_wr  input  1  write request level, held until ack
- i0_rd / i1_rd  input  1  read request level, held until ack
- i0_rdat / i1_rdat  output  DATA_W  read data, valid only when the matching ack is high
- i0_ack / i1_ack  output  1  one-cycle completion pulse
- r_addr  output  ADDR_W  registered address to responder
- r_wdat  output  DATA_W  registered write data to responder
- r_wr / r_rd  output  1  one-cycle strobes to responder
- r_rdat  input  DATA_W  responder read data, valid with r_ack
- r_ack  input  1  responder completion pulse
- err_clr  input  1  clears timeout_err
- timeout_err  output  1  sticky; set on any timeout

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - An initiator requests when wr or rd is high.
  - If only one initiator requests, grant it.
  - If both request, grant the initiator that is not last_gnt. last_gnt resets to 1, so i0 wins the first tie.
  - On a grant: latch gnt, addr, wdat and the op into r_addr/r_wdat/op_q; update last_gnt; go to ISSUE.
  - If wr and rd are both high on the granted initiator, it is a write and rd is ignored.
- **ISSUE**
  - Drive r_wr or r_rd for exactly this one cycle.
  - Load the timeout counter with 1.
  - If r_ack is high in this cycle, capture r_rdat and go to ACK. Otherwise go to WAIT.
- **WAIT**
  - Strobes are low.
  - On r_ack: capture r_rdat and go to ACK.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC without an ack: set rdat_q = REG_ERR_RDAT (16'hDEAD), set timeout_err, go to ACK.
- **ACK**
  - Pulse the granted iN_ack for one cycle, with iN_rdat = rdat_q. The other initiator's outputs stay 0.
  - Go to IDLE. The initiator drops its request on the cycle after the ack, so IDLE never re-grants the same access.
- Writes also pass r_rdat (or the error word on timeout) to rdat; initiators ignore it on writes.
- r_ack outside ISSUE/WAIT is ignored, and a late ack after a timeout is discarded.
- A request that arrives during a transaction waits; the requester holds its signals until it is acked.
- timeout_err: set has priority over err_clr in the same cycle; err_clr alone clears it next cycle.
- iN_rdat is driven as 0 whenever iN_ack is low.

## Timing
- Reset (async assert, sync release) drives all of the following to 0: state (IDLE), r_wr, r_rd, r_addr, r_wdat, i0/i1_ack, i0/i1_rdat, timeout_err, counter, rdat_q. last_gnt resets to 1.
- Reset mid-transaction abandons the access with no ack; the initiator must re-request.
- Minimum latency (responder acks in the strobe cycle):
  - cycle 0: request seen in IDLE
  - cycle 1: strobe
  - cycle 2: iN_ack
- With the responder acking k cycles after the strobe, iN_ack appears at cycle 2+k.
- Timeout path: ISSUE at cycle 1, iN_ack at cycle TIMEOUT_CYC+1.
- Back-to-back throughput is one transaction per 3 cycles minimum (IDLE, ISSUE, ACK).
- All outputs are registered; there is no combinational path from input to output.

## Structure
- The following belong in rtmc_pkg:
  - typedef enum logic [1:0] reg_arb_state_t {IDLE, ISSUE, WAIT, ACK}
  - localparam REG_ERR_RDAT = 16'hDEAD
- Ports are flat signals rather than interface ports. Simulation-only wrappers may bind them to reg_if initiator/responder modports.
- Single flat module: the two-way round-robin pick and the 8-bit timeout counter are small enough to stay inline. No sub-module.

## Test plan
- **Single write:** i0 writes addr 0x12, wdat 0xBEEF; responder acks 2 cycles after the strobe. Expect:
  - r_wr high for exactly 1 cycle with r_addr=0x12, r_wdat=0xBEEF
  - i0_ack at cycle 4
  - i1_ack never asserted
- **Read data return:** i1 reads addr 0x05; responder returns 0x1234 with r_ack in the strobe cycle. Expect i1_ack at cycle 2 with i1_rdat=0x1234, and i1_rdat=0 in all other cycles.
- **Simultaneous requests:** both initiators hold requests continuously. Expect:
  - grants alternate i0, i1, i0, i1
  - one r_wr/r_rd strobe per grant
  - each initiator acked only for its own access
- **Timeout:** TIMEOUT_CYC=15; the responder never acks an i0 read. Expect:
  - i0_ack at cycle 16 with i0_rdat=0xDEAD
  - timeout_err=1 and held
  - a late r_ack is ignored
  - err_clr pulse clears timeout_err one cycle later
- **Reset mid-transaction:** assert rst while in WAIT. Expect:
  - all outputs 0 immediately (async)
  - no ack for the abandoned access
  - after release, a held i1 request is granted first, because last_gnt reset to 1 puts i0 ahead only on a tie
- **Conflicting op:** i0 asserts wr and rd together. Expect only r_wr to strobe, and r_rd to stay 0.
